// File: rtl/gomoku_pkg.sv
// Shared types and constants for the gomoku keypad scanner.
package gomoku_pkg;

  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } kb_state_e;

  // Active-low one-hot column drive, indexed by column number.
  localparam logic [3:0][3:0] COL_DRIVE = {4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef struct packed {
    logic             single;
    logic [KEY_W-1:0] code;
  } kb_frame_t;

endpackage

// File: rtl/gomoku_kb_frame_decode.sv
// Reduces one 4x4 scan frame to a single key code, or NONE when zero or several keys are down.
module gomoku_kb_frame_decode
  import gomoku_pkg::*;
(
  input  logic [3:0][3:0] frame_rows,  // [col][row bit], active-low, row 0 = bit 3
  output kb_frame_t       res
);

  logic [4:0]       n_low;
  logic [KEY_W-1:0] code;

  always_comb begin
    n_low = '0;
    code  = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!frame_rows[c][3-r]) begin
          n_low = n_low + 5'd1;
          code  = KEY_W'(r * 4 + c);
        end
      end
    end
    res.single = (n_low == 5'd1);
    res.code   = code;
  end

endmodule

// File: rtl/gomoku_keypad_scan.sv
// 4x4 keypad scanner with frame-level debounce and board coordinate latching.
module gomoku_keypad_scan
  import gomoku_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scan_tick,
  input  logic [3:0]       keyboard_row,
  input  logic             pos_clear,
  output logic [3:0]       keyboard_col,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_code,
  output logic             key_held,
  output logic [2:0]       pos_x,
  output logic [2:0]       pos_y,
  output logic             pos_x_set,
  output logic             pos_y_set,
  output logic             pos_ready
);

  logic [1:0]       col_q;
  logic [2:0][3:0]  row_q;
  kb_state_e        state_q, state_d;
  logic [3:0]       cnt_q, cnt_d, cnt_inc;
  logic [KEY_W-1:0] cand_q, cand_d, code_d;
  logic             kv_d;
  logic             frame_close, hit_cand, hit_key, db_done;
  kb_frame_t        fr;

  assign keyboard_col = COL_DRIVE[col_q];
  assign frame_close  = scan_tick && (col_q == 2'd3);

  // Column 3 is decoded straight from the pins on the closing tick.
  gomoku_kb_frame_decode u_dec (
    .frame_rows ({keyboard_row, row_q[2], row_q[1], row_q[0]}),
    .res        (fr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= 2'd0;
      row_q <= '1;
    end else if (scan_tick) begin
      if (col_q != 2'd3) row_q[col_q] <= keyboard_row;
      col_q <= col_q + 2'd1;
    end
  end

  assign hit_cand = fr.single && (fr.code == cand_q);
  assign hit_key  = fr.single && (fr.code == key_code);
  assign cnt_inc  = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
  assign db_done  = (cnt_inc >= 4'(DEBOUNCE_FRAMES));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = key_code;
    kv_d    = 1'b0;
    if (frame_close) begin
      unique case (state_q)
        ST_IDLE: begin
          if (fr.single) begin
            state_d = ST_PRESS_DB;
            cand_d  = fr.code;
            cnt_d   = 4'd1;
          end
        end
        ST_PRESS_DB: begin
          if (hit_cand) begin
            cnt_d = cnt_inc;
            if (db_done) begin
              state_d = ST_HELD;
              code_d  = cand_q;
              kv_d    = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end
        end
        ST_HELD: begin
          if (!hit_key) begin
            state_d = ST_RELEASE_DB;
            cnt_d   = 4'd1;
          end
        end
        ST_RELEASE_DB: begin
          if (hit_key) begin
            state_d = ST_HELD;
          end else begin
            cnt_d = cnt_inc;
            if (db_done) begin
              state_d = ST_IDLE;
              cnt_d   = 4'd0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      cand_q    <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      key_code  <= code_d;
      key_valid <= kv_d;
    end
  end

  assign key_held = (state_q == ST_HELD) || (state_q == ST_RELEASE_DB);

  // A clear in the same cycle as key_valid still lets the new key set its flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x     <= 3'd0;
      pos_y     <= 3'd0;
      pos_x_set <= 1'b0;
      pos_y_set <= 1'b0;
    end else begin
      if (key_valid && key_code[3])  pos_x <= key_code[2:0];
      if (key_valid && !key_code[3]) pos_y <= key_code[2:0];
      pos_x_set <= (pos_x_set && !pos_clear) || (key_valid && key_code[3]);
      pos_y_set <= (pos_y_set && !pos_clear) || (key_valid && !key_code[3]);
    end
  end

  assign pos_ready = pos_x_set && pos_y_set;

endmodule

// File: tb/tb_gomoku_keypad_scan.sv
// Scoreboard bench for gomoku_keypad_scan: a keypad model drives the rows, expected key events are queued.
module tb_gomoku_keypad_scan;
  import gomoku_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             scan_tick = 1'b0;
  logic [3:0]       keyboard_row;
  logic             pos_clear = 1'b0;
  logic [3:0]       keyboard_col;
  logic             key_valid;
  logic [KEY_W-1:0] key_code;
  logic             key_held;
  logic [2:0]       pos_x, pos_y;
  logic             pos_x_set, pos_y_set, pos_ready;

  logic [15:0]      keys = '0;  // bit k set = key code k pressed
  logic [3:0]       exp_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;

  gomoku_keypad_scan #(.DEBOUNCE_FRAMES(4)) dut (
    .clk(clk), .rst_n(rst_n), .scan_tick(scan_tick), .keyboard_row(keyboard_row),
    .pos_clear(pos_clear), .keyboard_col(keyboard_col), .key_valid(key_valid),
    .key_code(key_code), .key_held(key_held), .pos_x(pos_x), .pos_y(pos_y),
    .pos_x_set(pos_x_set), .pos_y_set(pos_y_set), .pos_ready(pos_ready)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    keyboard_row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!keyboard_col[3-c])
        for (int r = 0; r < 4; r++)
          if (keys[r*4+c]) keyboard_row[3-r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && key_valid) begin
      if (exp_q.size() == 0) chk("kv_unexpected", {28'd0, key_code}, 32'hFFFF);
      else chk("kv_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
    end
  end

  // Runs n full frames with random 0/1-cycle gaps between ticks; optionally
  // pulses pos_clear in the cycle where the last frame's key_valid appears.
  task automatic frames(input int n, input bit clr_last = 1'b0);
    for (int i = 0; i < 4 * n; i++) begin
      scan_tick = 1'b1;
      @(posedge clk); #1;
      scan_tick = 1'b0;
      if (clr_last && i == 4 * n - 1) begin
        pos_clear = 1'b1;
        @(posedge clk); #1;
        pos_clear = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic press_accept(input logic [3:0] k, input bit clr_last = 1'b0);
    keys = '0;
    keys[k] = 1'b1;
    frames(3);
    exp_q.push_back(k);
    frames(1, clr_last);
    chk("kv_seen", exp_q.size(), 0);
  endtask

  task automatic release_all();
    keys = '0;
    frames(4);
    chk("released", {31'd0, key_held}, 0);
  endtask

  task automatic clear_pulse();
    pos_clear = 1'b1;
    @(posedge clk); #1;
    pos_clear = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col", keyboard_col, 4'h7);
    chk("rst_kv", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_held", key_held, 0);
    chk("rst_pos", {pos_x, pos_y, pos_x_set, pos_y_set, pos_ready}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Column walk, last tick back-to-back with the previous one
    scan_tick = 1'b1; @(posedge clk); #1; scan_tick = 1'b0;
    chk("col1", keyboard_col, 4'hB);
    scan_tick = 1'b1; @(posedge clk); #1; scan_tick = 1'b0;
    chk("col2", keyboard_col, 4'hD);
    scan_tick = 1'b1; @(posedge clk); #1;
    chk("col3", keyboard_col, 4'hE);
    @(posedge clk); #1; scan_tick = 1'b0;
    chk("col0_wrap", keyboard_col, 4'h7);

    // Key 0xA held 6 frames
    press_accept(4'hA);
    frames(2);
    chk("a_code", key_code, 4'hA);
    chk("a_held", key_held, 1);
    chk("a_pos_x", pos_x, 2);
    chk("a_x_set", pos_x_set, 1);
    chk("a_y_set", pos_y_set, 0);
    keys = '0;
    frames(3);
    chk("a_rel_db_held", key_held, 1);
    frames(1);
    chk("a_rel_done", key_held, 0);

    // Key 0x3 bounced short, then a full press from a fresh count
    keys = 16'h0008;
    frames(3);
    keys = '0;
    frames(1);
    chk("short_held", key_held, 0);
    frames(3);
    press_accept(4'h3);
    chk("s3_pos_y", pos_y, 3);
    release_all();

    // 0x9 then 0x5 -> ready, then clear
    clear_pulse();
    chk("clr_ready0", pos_ready, 0);
    press_accept(4'h9);
    release_all();
    chk("x_only_ready", pos_ready, 0);
    press_accept(4'h5);
    release_all();
    chk("xy_pos_x", pos_x, 1);
    chk("xy_pos_y", pos_y, 5);
    chk("xy_ready", pos_ready, 1);
    clear_pulse();
    chk("clr_ready", pos_ready, 0);
    chk("clr_keep", {pos_x, pos_y}, {3'd1, 3'd5});

    // Two keys down -> nothing; drop one -> the other debounces
    keys = 16'h0042;
    frames(6);
    chk("multi_held", key_held, 0);
    press_accept(4'h1);
    chk("multi_code", key_code, 1);
    release_all();

    // One-frame glitch on a held 0xF
    press_accept(4'hF);
    keys = '0;
    frames(1);
    keys = 16'h8000;
    frames(3);
    chk("glitch_held", key_held, 1);
    chk("glitch_code", key_code, 4'hF);
    release_all();

    // pos_clear coincident with key_valid
    press_accept(4'h2);
    release_all();
    chk("pre_y_set", pos_y_set, 1);
    press_accept(4'hC, 1'b1);
    chk("coinc_x_set", pos_x_set, 1);
    chk("coinc_pos_x", pos_x, 4);
    chk("coinc_y_set", pos_y_set, 0);
    chk("coinc_pos_y", pos_y, 2);
    release_all();

    // Reset mid-debounce with the key still down
    keys = 16'h0020;
    frames(2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_col", keyboard_col, 4'h7);
    chk("mid_rst_out", {key_valid, key_code, key_held, pos_x, pos_y, pos_x_set, pos_y_set}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    frames(3);
    exp_q.push_back(4'h5);
    frames(1);
    chk("post_rst_kv", exp_q.size(), 0);
    chk("post_rst_y", pos_y, 5);
    release_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gomoku_keypad_scan.md
GOMOKU_KEYPAD_SCAN -- requirements
Module: gomoku_keypad_scan

Interface
REQ-001 Parameter DEBOUNCE_FRAMES, default 4, is the number of consecutive identical scan frames required to accept a press or a release (legal range 2..15).
REQ-002 clk  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 scan_tick  input  1  one-cycle column-advance strobe, synchronous to clk.
REQ-005 keyboard_row  input  4  keypad row lines, active-low; row index 0 = bit 3.
REQ-006 pos_clear  input  1  one-cycle request to discard the latched position (driven on move commit).
REQ-007 keyboard_col  output  4  column drive, one-hot active-low: col0 = 0111, col1 = 1011, col2 = 1101, col3 = 1110.
REQ-008 key_valid  output  1  one-cycle pulse on an accepted press.
REQ-009 key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the last accepted key.
REQ-010 key_held  output  1  high while an accepted key is debounced-held.
REQ-011 pos_x, pos_y  output  3 each  latched board coordinates.
REQ-012 pos_x_set, pos_y_set  output  1 each  coordinate latched since the last clear.
REQ-013 pos_ready  output  1  pos_x_set AND pos_y_set.

Function
REQ-014 Column counter SHALL advance 0->1->2->3->0 on each scan_tick; keyboard_col SHALL decode the counter combinationally from the register.
REQ-015 On scan_tick, keyboard_row SHALL be sampled for the current column before the counter advances; four samples form one frame, closed at the tick on column 3.
REQ-016 Frame result: a single key if exactly one row bit is low across all four columns; otherwise NONE (no key, or multiple keys, including two keys in one column).
REQ-017 FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB; state and frame counter change only at frame close.
REQ-018 IDLE: single key K -> PRESS_DB, candidate = K, count = 1; NONE -> stay.
REQ-019 PRESS_DB: frame equal to candidate -> count+1; when count reaches DEBOUNCE_FRAMES -> HELD; any other result -> IDLE.
REQ-020 Entering HELD SHALL register key_code = candidate and assert key_valid for exactly the one clk cycle after the closing tick.
REQ-021 HELD: frame equal to key_code -> stay; any other result (NONE or a different key) -> RELEASE_DB, count = 1.
REQ-022 RELEASE_DB: frame not equal to key_code -> count+1; when count reaches DEBOUNCE_FRAMES -> IDLE; frame equal to key_code -> HELD with no new key_valid.
REQ-023 A key change without an intervening debounced release SHALL never produce key_valid.
REQ-024 key_held SHALL be 1 in HELD and RELEASE_DB, 0 otherwise.
REQ-025 On key_valid: code >= 8 -> pos_x = code[2:0], pos_x_set = 1; code < 8 -> pos_y = code[2:0], pos_y_set = 1; re-entry overwrites.
REQ-026 pos_clear SHALL zero pos_x_set and pos_y_set; pos_x/pos_y values are retained.
REQ-027 pos_clear and key_valid in the same cycle: clear applies first, then the new key sets its coordinate.
REQ-028 Frame counter saturates at 15; a scan_tick arriving on consecutive cycles SHALL be legal.

Reset
REQ-029 rst_n low SHALL force: column 0 (keyboard_col = 0111), state IDLE, count 0, key_valid 0, key_code 0, key_held 0, pos_x = pos_y = 0, both set flags 0.
REQ-030 Reset mid-debounce or mid-hold SHALL discard the candidate; after release a held key is re-debounced from IDLE and produces one key_valid.

Structure
REQ-031 A shared package gomoku_pkg SHALL hold the FSM state encoding, the four column drive patterns, and the KEY_W = 4 width constant.
REQ-032 One sub-module, gomoku_kb_frame_decode, is natural: it takes the four row samples and returns {single, code}, purely combinationally.

Verification
REQ-033 Key 0xA (row 2, col 2) held 6 frames, DEBOUNCE_FRAMES = 4 -> one key_valid, key_code = 0xA, pos_x = 2, pos_x_set = 1.
REQ-034 Key 0x3 held for 3 frames, then released -> no key_valid, state returns to IDLE.
REQ-035 Keys 0x9 then 0x5, each pressed and released cleanly -> pos_x = 1, pos_y = 5, pos_ready = 1; pos_clear -> pos_ready = 0.
REQ-036 Keys 0x1 and 0x6 pressed together -> no key_valid; release 0x6 only -> after 4 frames, key_valid with key_code = 0x1.
REQ-037 Key 0xF held, then a 1-frame glitch to NONE -> no second key_valid; key_held stays 1.
REQ-038 rst_n asserted in PRESS_DB, key still held after reset -> keyboard_col = 0111, outputs zero; exactly one key_valid 4 frames after reset release.
